// File: rtl/core_pkg.sv
// Shared types for the load/store unit: FSM states, op encoding and strobe patterns.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FIN  = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      store;
    lsu_size_e size;
    logic      uns;
  } lsu_op_t;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_HLO  = 4'b0011;
  localparam logic [3:0] STRB_HHI  = 4'b1100;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Flag order {SW,SH,SB,LW,LH,LHU,LB,LBU}; the leftmost set flag wins.
  function automatic lsu_op_t decode_op(input logic [7:0] flags);
    lsu_op_t op;
    op = '{store: 1'b0, size: SZ_BYTE, uns: 1'b1};
    if (flags[7])      op = '{store: 1'b1, size: SZ_WORD, uns: 1'b0};
    else if (flags[6]) op = '{store: 1'b1, size: SZ_HALF, uns: 1'b0};
    else if (flags[5]) op = '{store: 1'b1, size: SZ_BYTE, uns: 1'b0};
    else if (flags[4]) op = '{store: 1'b0, size: SZ_WORD, uns: 1'b0};
    else if (flags[3]) op = '{store: 1'b0, size: SZ_HALF, uns: 1'b0};
    else if (flags[2]) op = '{store: 1'b0, size: SZ_HALF, uns: 1'b1};
    else if (flags[1]) op = '{store: 1'b0, size: SZ_BYTE, uns: 1'b0};
    return op;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Lane logic: alignment check, store strobes/replication and load extraction/extension.
module core_lsu_align
  import core_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  lsu_op_t     op;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign op     = lsu_op_t'(op_i);
  assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
  end

  always_comb begin
    misalign_o = 1'b0;
    wstrb_o    = STRB_NONE;
    wdata_o    = 32'd0;
    rdata_o    = rdata_i;
    case (op.size)
      SZ_BYTE: begin
        rdata_o = op.uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
        if (op.store) begin
          wstrb_o = STRB_B0 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
      end
      SZ_HALF: begin
        misalign_o = addr_lo_i[0];
        rdata_o    = op.uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
        if (op.store) begin
          wstrb_o = addr_lo_i[1] ? STRB_HHI : STRB_HLO;
          wdata_o = {2{wdata_i[15:0]}};
        end
      end
      default: begin
        misalign_o = |addr_lo_i;
        if (op.store) begin
          wstrb_o = STRB_WORD;
          wdata_o = wdata_i;
        end
      end
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one request/acknowledge bus transaction per START, with
// misalignment detection and a bounded wait for MEM_ACK.
module core_lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        I_LB,
  input  logic        I_LH,
  input  logic        I_LW,
  input  logic        I_LBU,
  input  logic        I_LHU,
  input  logic        I_SB,
  input  logic        I_SH,
  input  logic        I_SW,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_WSTRB,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RDATA,
  output logic        ERR_MISALIGN,
  output logic        ERR_BUS
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q;
  lsu_op_t          op_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_req_q, mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_wstrb_q;
  logic             busy_q, done_q, err_mis_q, err_bus_q;
  logic [31:0]      rdata_q;

  logic [7:0]  flags;
  lsu_op_t     op_d;
  lsu_op_t     op_sel;
  logic [1:0]  addr_sel;
  logic        start_d;
  logic        misalign;
  logic [3:0]  wstrb;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;

  assign flags   = {I_SW, I_SH, I_SB, I_LW, I_LH, I_LHU, I_LB, I_LBU};
  assign op_d    = decode_op(flags);
  assign start_d = START && (|flags);

  // In IDLE the lane logic sees the incoming request; afterwards the latched one.
  assign op_sel   = (state_q == ST_IDLE) ? op_d : op_q;
  assign addr_sel = (state_q == ST_IDLE) ? ADDR[1:0] : addr_lo_q;

  core_lsu_align u_align (
    .op_i      (op_sel),
    .addr_lo_i (addr_sel),
    .wdata_i   (WDATA),
    .rdata_i   (MEM_RDATA),
    .misalign_o(misalign),
    .wstrb_o   (wstrb),
    .wdata_o   (wdata_rep),
    .rdata_o   (ld_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_lo_q   <= 2'd0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wstrb_q <= STRB_NONE;
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_mis_q   <= 1'b0;
      err_bus_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      done_q    <= 1'b0;
      err_mis_q <= 1'b0;
      err_bus_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            op_q      <= op_d;
            addr_lo_q <= ADDR[1:0];
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (misalign) begin
              state_q   <= ST_FIN;
              done_q    <= 1'b1;
              err_mis_q <= 1'b1;
            end else begin
              state_q     <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= op_d.store;
              mem_addr_q  <= {ADDR[31:2], 2'b00};
              mem_wstrb_q <= wstrb;
              mem_wdata_q <= wdata_rep;
            end
          end
        end
        ST_REQ: begin
          // ACK is checked first so a same-cycle ACK beats the timeout.
          if (MEM_ACK || (cnt_q == CNT_LAST)) begin
            state_q     <= ST_FIN;
            done_q      <= 1'b1;
            err_bus_q   <= !MEM_ACK;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= STRB_NONE;
            mem_wdata_q <= 32'd0;
            if (MEM_ACK && !op_q.store) rdata_q <= ld_data;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MEM_REQ      = mem_req_q;
  assign MEM_WE       = mem_we_q;
  assign MEM_ADDR     = mem_addr_q;
  assign MEM_WSTRB    = mem_wstrb_q;
  assign MEM_WDATA    = mem_wdata_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign RDATA        = rdata_q;
  assign ERR_MISALIGN = err_mis_q;
  assign ERR_BUS      = err_bus_q;

endmodule
